// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter fed by a small byte FIFO.
//
// Each frame is one start bit (low), UART_DATA_LENGTH data bits sent LSB first,
// and one stop bit (high), with no parity. Every bit lasts BAUD_COUNTS_PER_BIT
// clock cycles. While the FIFO holds data, frames go out back-to-back.
//
// Ports
//   clk_i              system clock, rising edge
//   reset_i            asynchronous reset, active low (0 = reset)
//   data_i             byte to enqueue
//   data_valid_strb_i  enqueue request; one byte is taken per high cycle
//   ready_o            FIFO can accept a byte this cycle
//   overflow_strb_o    one-cycle pulse after a strobe was refused
//   fifo_count_o       number of bytes waiting, 0..FIFO_DEPTH
//   busy_o             a frame is in progress
//   tx_o               serial line (registered), idles high
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | line high, waiting for a byte in the FIFO
// S_START | start bit, line low
// S_DATA  | data bits, line = shift_q[0]
// S_STOP  | stop bit, line high; chains into the next frame
module uart_tx #(
  parameter int UART_DATA_LENGTH           = 8,
  parameter int BAUD_COUNTS_PER_BIT        = 521,
  parameter int BAUD_RATE_COUNTER_BITWIDTH = 10,
  parameter int TX_COUNTER_BITWIDTH        = 3,
  parameter int FIFO_DEPTH                 = 4,
  parameter int FIFO_ADDR_WIDTH            = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [UART_DATA_LENGTH-1:0] data_i,
  input  logic                        data_valid_strb_i,
  output logic                        ready_o,
  output logic                        overflow_strb_o,
  output logic [FIFO_ADDR_WIDTH:0]    fifo_count_o,
  output logic                        busy_o,
  output logic                        tx_o
);

  localparam logic [BAUD_RATE_COUNTER_BITWIDTH-1:0] BAUD_LAST =
    BAUD_RATE_COUNTER_BITWIDTH'(BAUD_COUNTS_PER_BIT - 1);
  localparam logic [TX_COUNTER_BITWIDTH-1:0] BIT_LAST =
    TX_COUNTER_BITWIDTH'(UART_DATA_LENGTH - 1);
  localparam logic [FIFO_ADDR_WIDTH:0] FIFO_FULL = (FIFO_ADDR_WIDTH + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO
  logic [UART_DATA_LENGTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FIFO_ADDR_WIDTH:0]    count_q, count_d;
  logic                        push, pop;
  logic                        overflow_q;

  // Transmitter
  state_t                              state_q, state_d;
  logic [BAUD_RATE_COUNTER_BITWIDTH-1:0] baud_q, baud_d;
  logic [TX_COUNTER_BITWIDTH-1:0]      bit_idx_q, bit_idx_d;
  logic [UART_DATA_LENGTH-1:0]         shift_q, shift_d;
  logic                                tx_q, tx_d;
  logic                                baud_end;
  logic                                fifo_has_data;

  assign ready_o         = (count_q < FIFO_FULL);
  assign push            = data_valid_strb_i & ready_o;
  assign fifo_has_data   = (count_q != '0);
  assign fifo_count_o    = count_q;
  assign overflow_strb_o = overflow_q;
  assign busy_o          = (state_q != S_IDLE);
  assign tx_o            = tx_q;
  assign baud_end        = (baud_q == BAUD_LAST);

  // Storage needs no reset; only entries below the count are ever read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= data_i;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      overflow_q <= data_valid_strb_i & ~ready_o;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (fifo_has_data) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d    = '0;
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == BIT_LAST) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so frames stay contiguous.
          if (fifo_has_data) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // The line level is registered from the next state so it changes on the
  // same edge as the state itself, with no combinational path to the pin.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that pairs with the CPU's UART receiver, so the design can send bytes back over the same 8N1 link: one start bit, UART_DATA_LENGTH data bits LSB first, one stop bit, no parity. A small FIFO decouples the producer (control unit or debug logic) from the serial line. Frames go out back-to-back while the FIFO holds data. The block sits beside the receiver at the CPU top level, and `tx_o` drives the board's TX pin.

## Interface
- UART_DATA_LENGTH, 8, data bits per frame
- BAUD_COUNTS_PER_BIT, 521, clk_i cycles per serial bit (same value as the receiver)
- BAUD_RATE_COUNTER_BITWIDTH, 10, width of baud counter; must satisfy 2^W >= BAUD_COUNTS_PER_BIT
- TX_COUNTER_BITWIDTH, 3, width of data-bit index; must satisfy 2^W >= UART_DATA_LENGTH
- FIFO_DEPTH, 4, entries in the transmit FIFO; power of two
- FIFO_ADDR_WIDTH, 2, log2(FIFO_DEPTH)

Ports:
- clk_i  in  1  single system clock, rising edge
- reset_i  in  1  asynchronous, active-low reset (0 = reset)
- data_i  in  UART_DATA_LENGTH  byte to enqueue
- data_valid_strb_i  in  1  enqueue request, one byte per high cycle
- ready_o  out  1  FIFO can accept a byte this cycle
- overflow_strb_o  out  1  one-cycle pulse when a strobe is refused
- fifo_count_o  out  FIFO_ADDR_WIDTH+1  bytes waiting, range 0..FIFO_DEPTH
- busy_o  out  1  frame in progress
- tx_o  out  1  serial line, idles high

## Operation
- Reset values: tx_o=1, busy_o=0, ready_o=1, overflow_strb_o=0, fifo_count_o=0. FIFO pointers, shift register, counters and FSM are cleared; state is IDLE.
- Reset takes effect asynchronously. A frame interrupted by reset is lost. tx_o returns high immediately.
- ready_o is (fifo_count_o < FIFO_DEPTH), decoded combinationally from the registered count.
- Push: data_valid_strb_i=1 and ready_o=1 writes data_i at the write pointer. The pointer wraps modulo FIFO_DEPTH.
- Refused strobe: data_valid_strb_i=1 and ready_o=0. Data is dropped and overflow_strb_o=1 the next cycle, for exactly one cycle.
- Pop: the FSM reads the head into the shift register and advances the read pointer. The pointer wraps.
- Simultaneous push and pop: both take effect and the count is unchanged. A push into a full FIFO is refused even if a pop happens the same cycle.
- FSM states:
  - IDLE: tx_o=1. If the count is nonzero, pop and go to START.
  - START: tx_o=0 for BAUD_COUNTS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx_o = shift[0] for BAUD_COUNTS_PER_BIT cycles, then shift right and increment the index. After bit UART_DATA_LENGTH-1, go to STOP.
  - STOP: tx_o=1 for BAUD_COUNTS_PER_BIT cycles. At the end, if the count is nonzero, pop and go straight to START with no idle cycle; otherwise go to IDLE.
- Baud counter: counts 0..BAUD_COUNTS_PER_BIT-1, resets to 0 on every bit boundary and on every state change.
- busy_o = (state != IDLE).
- tx_o is driven from a flop; no combinational path to the pin.

## Timing
- Frame length is exactly (UART_DATA_LENGTH+2) × BAUD_COUNTS_PER_BIT cycles.
- Push latency: a strobe sampled at edge N is reflected in fifo_count_o after edge N.
- Start latency from idle with an empty FIFO:
  - strobe sampled at edge N;
  - pop and START entry at edge N+1;
  - tx_o low from edge N+1;
  - busy_o high from edge N+1.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- busy_o falls on the edge that ends the final stop bit when the FIFO is empty.

## Test plan
All cases use UART_DATA_LENGTH=8, BAUD_COUNTS_PER_BIT=4, FIFO_DEPTH=4.
- Single byte: strobe 0xA5 while idle.
  - tx_o = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total).
  - busy_o high for exactly 40 cycles; fifo_count_o 1→0 one cycle after the strobe.
- LSB order: strobe 0x01 → the first data bit is 1 and the next 7 data bits are 0.
- Back-to-back: strobe 0x00, then 0xFF on the next cycle.
  - 80 contiguous busy cycles.
  - Start bit of the second frame immediately follows the stop bit of the first; tx_o never high for more than 4 cycles between frames.
- Overflow: during a frame, strobe 5 bytes on 5 consecutive cycles.
  - First 4 accepted; fifo_count_o=4; ready_o=0.
  - The 5th gives a single overflow_strb_o pulse and is never transmitted.
  - The 4 queued bytes go out in order.
- Push/pop collision: FIFO at count 2; strobe a byte on the exact cycle STOP ends → fifo_count_o stays 2 and no byte is lost.
- Reset mid-frame: drive reset_i low during data bit 3.
  - tx_o=1, busy_o=0, fifo_count_o=0 immediately, without waiting for a clock edge.
  - After release, tx_o stays 1 and no frame resumes.
